// File: rtl/miriscv_lsu_pkg.sv
// Shared types and helpers for the pipelined load/store unit: size codes,
// the per-transaction tag kept while in flight, and lane/extension helpers.
package miriscv_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [1:0] off;
    logic       killed;
  } lsu_tag_t;

  // Stores only accept signed size codes; unsigned codes are load-only.
  function automatic logic lsu_legal(input logic we, input logic [2:0] size,
                                     input logic [1:0] off);
    case (size)
      LSU_B:          lsu_legal = 1'b1;
      LSU_BU:         lsu_legal = ~we;
      LSU_H:          lsu_legal = ~off[0];
      LSU_HU:         lsu_legal = ~we & ~off[0];
      LSU_W:          lsu_legal = (off == 2'b00);
      default:        lsu_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LSU_B, LSU_BU: be_gen = 4'b0001 << off;
      LSU_H, LSU_HU: be_gen = 4'b0011 << off;
      default:       be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] size, input logic [31:0] wdata);
    case (size)
      LSU_B:   wdata_rep = {4{wdata[7:0]}};
      LSU_H:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] w_sh;
    w_sh = rdata >> {off, 3'b000};
    case (size)
      LSU_B:   load_align = {{24{w_sh[7]}}, w_sh[7:0]};
      LSU_BU:  load_align = {24'h0, w_sh[7:0]};
      LSU_H:   load_align = {{16{w_sh[15]}}, w_sh[15:0]};
      LSU_HU:  load_align = {16'h0, w_sh[15:0]};
      default: load_align = w_sh;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_tag_fifo.sv
// In-order tag queue for in-flight memory transactions; kill marks every
// stored entry, while an entry pushed on the same edge stays live.
module miriscv_lsu_tag_fifo
  import miriscv_lsu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  lsu_tag_t         i_tag,
  input  logic             i_pop,
  input  logic             i_kill_all,
  output lsu_tag_t         o_head,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_tag_t           r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_kill_all) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i].killed <= 1'b1;
      end
      // The push write follows the kill loop so a same-edge push stays unkilled.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_tag;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/miriscv_lsu_pipe.sv
// Pipelined LSU: up to MAX_OUTSTANDING req/gnt/rvalid memory transactions,
// in-order registered responses one cycle after data_rvalid_i, with kill.
module miriscv_lsu_pipe
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic              lsu_kill_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              lsu_busy_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (XLEN != 32) begin : g_bad_xlen
    $error("miriscv_lsu_pipe: XLEN must be 32");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_depth
    $error("miriscv_lsu_pipe: MAX_OUTSTANDING must be 1..8");
  end

  logic             w_legal;
  logic             w_room;
  logic             w_mem_gnt;
  logic             w_err_gnt;
  logic             w_retire;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt;
  lsu_tag_t         w_head;
  lsu_tag_t         w_push_tag;

  logic             r_rvalid;
  logic             r_err;
  logic [XLEN-1:0]  r_rdata;

  assign w_legal = lsu_legal(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);
  // A retire in the same cycle frees a slot, so a full queue can still issue.
  assign w_room  = (w_cnt < CNT_W'(MAX_OUTSTANDING)) | data_rvalid_i;

  assign data_req_o = arstn_i & lsu_req_i & w_legal & w_room;
  assign w_mem_gnt  = data_req_o & data_gnt_i;
  // Illegal requests are answered only once the pipe is empty, keeping order.
  assign w_err_gnt  = arstn_i & lsu_req_i & ~w_legal & (w_cnt == '0);
  assign lsu_gnt_o  = w_mem_gnt | w_err_gnt;

  assign w_retire   = arstn_i & data_rvalid_i & (w_cnt != '0);
  assign w_drop     = w_head.killed | lsu_kill_i;

  assign data_we_o    = lsu_we_i;
  assign data_be_o    = be_gen(lsu_size_i, lsu_addr_i[1:0]);
  assign data_addr_o  = {lsu_addr_i[XLEN-1:2], 2'b00};
  assign data_wdata_o = wdata_rep(lsu_size_i, lsu_wdata_i);

  assign w_push_tag = '{we: lsu_we_i, size: lsu_size_i, off: lsu_addr_i[1:0], killed: 1'b0};

  miriscv_lsu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .i_clk      (clk_i),
    .i_rst_n    (arstn_i),
    .i_push     (w_mem_gnt),
    .i_tag      (w_push_tag),
    .i_pop      (w_retire),
    .i_kill_all (lsu_kill_i),
    .o_head     (w_head),
    .o_cnt      (w_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= (w_retire & ~w_drop) | w_err_gnt;
      r_err    <= w_err_gnt;
      r_rdata  <= (w_retire & ~w_drop & ~w_head.we)
                  ? load_align(w_head.size, w_head.off, data_rdata_i) : '0;
    end
  end

  assign lsu_rvalid_o = r_rvalid;
  assign lsu_err_o    = r_err;
  assign lsu_rdata_o  = r_rdata;
  assign lsu_busy_o   = (w_cnt != '0);

endmodule

// File: tb/tb_miriscv_lsu_pipe.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_miriscv_lsu_pipe;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i, lsu_we_i, lsu_kill_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o, lsu_busy_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

  always #5 clk = ~clk;

  miriscv_lsu_pipe #(.XLEN(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_kill_i(lsu_kill_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .lsu_busy_o(lsu_busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    bit       we;
    bit [2:0] size;
    bit [1:0] off;
    bit       killed;
  } ent_t;

  ent_t      q[$];
  int        checks = 0;
  int        errors = 0;
  bit        exp_rv, exp_err, last_gnt;
  bit [31:0] exp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_m(input bit we, input bit [2:0] size, input bit [31:0] addr);
    case (size)
      3'd0:       return 1'b1;
      3'd1:       return addr[0] == 1'b0;
      3'd2:       return addr[1:0] == 2'd0;
      3'd4, 3'd5: return (size == 3'd4 || addr[0] == 1'b0) && !we;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] align_m(input bit [2:0] size, input bit [1:0] off, input bit [31:0] rdata);
    bit [31:0] v;
    byte       b;
    shortint   h;
    v = rdata >> (8 * off);
    b = v[7:0];
    h = v[15:0];
    case (size)
      3'd0:    return 32'(int'(b));
      3'd1:    return 32'(int'(h));
      3'd4:    return v & 32'h0000_00FF;
      3'd5:    return v & 32'h0000_FFFF;
      default: return v;
    endcase
  endfunction

  function automatic bit [3:0] be_m(input bit [2:0] size, input bit [1:0] off);
    if (size == 3'd0 || size == 3'd4) return 4'(1 << off);
    if (size == 3'd1 || size == 3'd5) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic bit [31:0] wdata_m(input bit [2:0] size, input bit [31:0] d);
    if (size == 3'd0) return {4{d[7:0]}};
    if (size == 3'd1) return {2{d[15:0]}};
    return d;
  endfunction

  // Compare current outputs to the model, then advance the model across the coming edge.
  task automatic model_eval();
    int        cnt;
    bit        lg, e_req, e_gnt;
    ent_t      h;
    cnt   = q.size();
    lg    = legal_m(lsu_we_i, lsu_size_i, lsu_addr_i);
    e_req = arstn_i && lsu_req_i && lg && (cnt < MAXO || data_rvalid_i);
    e_gnt = lg ? (e_req && data_gnt_i) : (arstn_i && lsu_req_i && cnt == 0);
    chk("rvalid", lsu_rvalid_o, exp_rv);
    chk("err", lsu_err_o, exp_err);
    chk("rdata", lsu_rdata_o, exp_rdata);
    chk("busy", lsu_busy_o, cnt != 0);
    chk("data_req", data_req_o, e_req);
    chk("lsu_gnt", lsu_gnt_o, e_gnt);
    if (e_req) begin
      chk("be", data_be_o, be_m(lsu_size_i, lsu_addr_i[1:0]));
      chk("addr", data_addr_o, lsu_addr_i & ~32'h3);
      chk("we", data_we_o, lsu_we_i);
      chk("wdata", data_wdata_o, wdata_m(lsu_size_i, lsu_wdata_i));
    end
    exp_rv = 0; exp_err = 0; exp_rdata = 0;
    if (!arstn_i) begin
      q.delete();
    end else begin
      if (data_rvalid_i && cnt > 0) begin
        h = q.pop_front();
        if (!h.killed && !lsu_kill_i) begin
          exp_rv    = 1;
          exp_rdata = h.we ? 32'h0 : align_m(h.size, h.off, data_rdata_i);
        end
      end
      if (!lg && e_gnt) begin exp_rv = 1; exp_err = 1; end
      if (lsu_kill_i) foreach (q[i]) q[i].killed = 1;
      if (lg && e_gnt) q.push_back('{lsu_we_i, lsu_size_i, lsu_addr_i[1:0], 1'b0});
    end
    last_gnt = e_gnt;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle();
    lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 3'd2; lsu_addr_i = 0; lsu_wdata_i = 0;
    lsu_kill_i = 0; data_gnt_i = 1; data_rvalid_i = 0; data_rdata_i = 0;
  endtask

  task automatic req(input bit we, input bit [2:0] size, input bit [31:0] addr, input bit [31:0] wd);
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_wdata_i = wd;
  endtask

  task automatic rsp(input bit [31:0] d);
    data_rvalid_i = 1; data_rdata_i = d;
  endtask

  initial begin
    bit        pend;
    int        rst_cnt, stray;
    int        r;
    idle();
    arstn_i = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_rv = 0; exp_err = 0; exp_rdata = 0; last_gnt = 0;
    chk("reset_rvalid", lsu_rvalid_o, 0);
    chk("reset_busy", lsu_busy_o, 0);
    arstn_i = 1;

    // LW 0x100 -> 0xDEADBEEF
    req(0, 3'd2, 32'h100, 0); settle();
    chk("lw_be", data_be_o, 4'hF); chk("lw_addr", data_addr_o, 32'h100);
    advance(); idle(); tick();
    rsp(32'hDEADBEEF); tick(); idle();
    chk("lw_rvalid", lsu_rvalid_o, 1); chk("lw_rdata", lsu_rdata_o, 32'hDEADBEEF);

    // LB / LBU 0x103, third blocked until a retire, full queue issues on retire
    req(0, 3'd0, 32'h103, 0); settle(); chk("lb_be", data_be_o, 4'h8); advance();
    req(0, 3'd4, 32'h103, 0); settle(); chk("lbu_be", data_be_o, 4'h8); advance();
    req(0, 3'd2, 32'h200, 0); settle(); chk("third_blocked", data_req_o, 0); advance();
    rsp(32'h80123456); settle(); chk("full_retire_gnt", lsu_gnt_o, 1); advance();
    data_rvalid_i = 0;
    chk("lb_rdata", lsu_rdata_o, 32'hFFFFFF80);
    req(0, 3'd2, 32'h204, 0); settle(); chk("still_full", data_req_o, 0); advance();
    idle(); rsp(32'h80ABCDEF); tick();
    chk("lbu_rdata", lsu_rdata_o, 32'h00000080);
    rsp(32'h11223344); tick(); idle();
    chk("third_rdata", lsu_rdata_o, 32'h11223344);

    // Misaligned LH waits for the pipe to drain
    req(0, 3'd2, 32'h300, 0); tick();
    req(0, 3'd1, 32'h101, 0); settle(); chk("lh_noreq", data_req_o, 0); chk("lh_nognt", lsu_gnt_o, 0); advance();
    rsp(32'h0); settle(); chk("lh_wait", lsu_gnt_o, 0); advance();
    data_rvalid_i = 0; settle(); chk("lh_gnt", lsu_gnt_o, 1); advance(); idle();
    chk("lh_err", lsu_err_o, 1); chk("lh_rvalid", lsu_rvalid_o, 1); chk("lh_rdata", lsu_rdata_o, 0);

    // Kill with a new load granted in the kill cycle
    req(0, 3'd2, 32'h10, 0); tick();
    req(0, 3'd2, 32'h14, 0); tick();
    req(0, 3'd2, 32'h18, 0); lsu_kill_i = 1; rsp(32'hAAAA0000);
    settle(); chk("kill_gnt", lsu_gnt_o, 1); advance(); idle();
    chk("kill_drop1", lsu_rvalid_o, 0);
    rsp(32'hBBBB0000); tick(); chk("kill_drop2", lsu_rvalid_o, 0);
    rsp(32'h12345678); tick(); idle();
    chk("kill_survivor", lsu_rvalid_o, 1); chk("kill_survivor_data", lsu_rdata_o, 32'h12345678);

    // SH replication and store response
    req(1, 3'd1, 32'h202, 32'h0000ABCD); settle();
    chk("sh_be", data_be_o, 4'hC); chk("sh_wdata", data_wdata_o, 32'hABCDABCD); chk("sh_we", data_we_o, 1);
    advance(); idle();
    rsp(32'h55555555); tick(); idle();
    chk("sh_rvalid", lsu_rvalid_o, 1); chk("sh_rdata", lsu_rdata_o, 0);

    // Reset with one in flight, then a stray response
    req(0, 3'd2, 32'h40, 0); tick(); idle();
    arstn_i = 0; tick(); arstn_i = 1;
    chk("rst_busy", lsu_busy_o, 0); chk("rst_rvalid", lsu_rvalid_o, 0);
    rsp(32'hCAFEF00D); tick(); idle();
    chk("stray_rvalid", lsu_rvalid_o, 0); chk("stray_busy", lsu_busy_o, 0);

    // Randomized traffic
    pend = 0; rst_cnt = 0; stray = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend && last_gnt) pend = 0;
      if (!pend && $urandom_range(0, 9) < 6) begin
        pend = 1;
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: lsu_size_i = 3'(r);
          3:       lsu_size_i = 3'd4;
          4:       lsu_size_i = 3'd5;
          5, 6:    lsu_size_i = 3'd2;
          7:       lsu_size_i = 3'd0;
          8:       lsu_size_i = 3'd3;
          default: lsu_size_i = 3'd6;
        endcase
        lsu_we_i    = $urandom_range(0, 2) == 0;
        lsu_addr_i  = $urandom;
        lsu_wdata_i = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (lsu_size_i == 3'd2) lsu_addr_i[1:0] = 2'b00;
          if (lsu_size_i == 3'd1 || lsu_size_i == 3'd5) lsu_addr_i[0] = 1'b0;
        end
      end
      lsu_req_i     = pend;
      lsu_kill_i    = $urandom_range(0, 19) == 0;
      data_gnt_i    = $urandom_range(0, 9) < 7;
      data_rvalid_i = (q.size() > 0 && $urandom_range(0, 1) == 1) ||
                      (stray > 0 && $urandom_range(0, 1) == 1);
      data_rdata_i  = $urandom;
      if (c % 700 == 350) rst_cnt = 2;
      arstn_i = !(rst_cnt > 0);
      if (rst_cnt > 0) begin
        rst_cnt--;
        stray = 4;
      end else if (stray > 0) begin
        stray--;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
